// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant types and default parameters for the
// unified instruction/data memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arbState_e;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_e;
    localparam int          STARVE_MAX_DEF = 3;
    localparam int          TIMEOUT_DEF    = 64;
    localparam logic [31:0] ERR_DATA_DEF   = 32'hDEADBEEF;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the arbiter;
// master is the arbiter's view, slave is the surrounding pipeline/memory.
interface mem_arbiter_if;
    logic        if_req, if_ready;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ready;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        stall_f, stall_m;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        bus_err;
    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready, stall_f, stall_m,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready, stall_f, stall_m,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: per-access latency counter; expire flags the last
// allowed busy cycle so the arbiter can abort on that edge.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [7:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n || clr) cnt <= '0;
        else if (en) cnt <= cnt + 8'd1;
    end
    assign expire = en && cnt == 8'(TIMEOUT - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF fetches and MEM loads/stores onto one
// single-ported memory; data wins unless fetch has lost STARVE_MAX times.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          STARVE_MAX = STARVE_MAX_DEF,
    parameter int          TIMEOUT    = TIMEOUT_DEF,
    parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.master bus
);
    arbState_e   state, stateNext;
    grant_e      gnt;
    logic        memReq, memReqNext, memWe, memWeNext;
    logic        ifReady, ifReadyNext, dmReady, dmReadyNext, busErr, busErrNext;
    logic [31:0] memAddr, memAddrNext, memWdata, memWdataNext;
    logic [31:0] ifRdata, ifRdataNext, dmRdata, dmRdataNext, respData;
    logic [3:0]  starveCnt, starveCntNext;
    logic        busy, expire, done, fetchStarved, dataWins;

    assign busy         = state == BUSY_I || state == BUSY_D;
    assign gnt          = state == BUSY_I ? GNT_I : state == BUSY_D ? GNT_D : GNT_NONE;
    assign done         = busy && (bus.mem_ack || expire);
    assign respData     = bus.mem_ack ? bus.mem_rdata : ERR_DATA;
    assign fetchStarved = starveCnt >= 4'(STARVE_MAX);
    assign dataWins     = bus.dm_req && (!bus.if_req || !fetchStarved);

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!busy || bus.mem_ack),
        .en    (busy),
        .expire(expire)
    );

    always_comb begin
        stateNext     = state;
        memReqNext    = memReq;
        memWeNext     = memWe;
        memAddrNext   = memAddr;
        memWdataNext  = memWdata;
        ifRdataNext   = ifRdata;
        dmRdataNext   = dmRdata;
        ifReadyNext   = 1'b0;
        dmReadyNext   = 1'b0;
        busErrNext    = busErr;
        starveCntNext = starveCnt;
        case (state)
            IDLE: begin
                if (dataWins) begin
                    stateNext    = BUSY_D;
                    memReqNext   = 1'b1;
                    memWeNext    = bus.dm_we;
                    memAddrNext  = bus.dm_addr;
                    memWdataNext = bus.dm_wdata;
                    if (bus.if_req) starveCntNext = starveCnt + 4'd1;
                end else if (bus.if_req) begin
                    stateNext     = BUSY_I;
                    memReqNext    = 1'b1;
                    memWeNext     = 1'b0;
                    memAddrNext   = bus.if_addr;
                    starveCntNext = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (done) begin
                    stateNext   = RESP;
                    memReqNext  = 1'b0;
                    busErrNext  = busErr || !bus.mem_ack;
                    ifReadyNext = gnt == GNT_I;
                    dmReadyNext = gnt == GNT_D;
                    // a completed store leaves the load data register untouched
                    if (gnt == GNT_I) ifRdataNext = respData;
                    else if (!memWe || !bus.mem_ack) dmRdataNext = respData;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= '0;
            memWdata  <= '0;
            ifRdata   <= '0;
            dmRdata   <= '0;
            ifReady   <= 1'b0;
            dmReady   <= 1'b0;
            busErr    <= 1'b0;
            starveCnt <= '0;
        end else begin
            state     <= stateNext;
            memReq    <= memReqNext;
            memWe     <= memWeNext;
            memAddr   <= memAddrNext;
            memWdata  <= memWdataNext;
            ifRdata   <= ifRdataNext;
            dmRdata   <= dmRdataNext;
            ifReady   <= ifReadyNext;
            dmReady   <= dmReadyNext;
            busErr    <= busErrNext;
            starveCnt <= starveCntNext;
        end
    end

    assign bus.mem_req   = memReq;
    assign bus.mem_we    = memWe;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.if_rdata  = ifRdata;
    assign bus.dm_rdata  = dmRdata;
    assign bus.if_ready  = ifReady;
    assign bus.dm_ready  = dmReady;
    assign bus.bus_err   = busErr;
    assign bus.stall_f   = bus.if_req & ~ifReady;
    assign bus.stall_m   = bus.dm_req & ~dmReady;
endmodule
